multicycle_control: RTL and testbench

- Multi-cycle control FSM for the RV32I core; replaces purely combinational opcode decode with a sequenced controller.
- Drives instruction fetch, memory handshake, PC update and register write-back from IR fields.
- Adds LUI/AUIPC, an optional multi-cycle M-extension path, illegal-instruction detection and a memory-timeout trap.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 262 ++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Signal bundle between the multi-cycle controller and the RV32I datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [1:0] ALUOp;
  logic       ALUSrc;
  logic [1:0] alu_a_sel;
  logic       RegWrite;
  logic [1:0] wb_sel;
  logic       mul_start;
  logic       illegal_instr;
  logic       bus_error;
  logic [2:0] state_dbg;

  modport master (
    input  opcode, funct3, funct7, mem_ready, branch_taken,
    output mem_req, mem_we, ir_write, pc_write, pc_src, ALUOp, ALUSrc,
           alu_a_sel, RegWrite, wb_sel, mul_start, illegal_instr, bus_error,
           state_dbg
  );

  modport slave (
    output opcode, funct3, funct7, mem_ready, branch_taken,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, ALUOp, ALUSrc,
           alu_a_sel, RegWrite, wb_sel, mul_start, illegal_instr, bus_error,
           state_dbg
  );
endinterface

// File: rtl/multicycle_control.sv
// Sequenced RV32I controller: fetch, decode/legality check, execute, memory,
// write-back, optional M-extension wait, and sticky illegal/bus-error traps.
module multicycle_control #(
  parameter int unsigned ENABLE_M     = 0,
  parameter int unsigned MUL_LAT      = 4,
  parameter int unsigned MAX_MEM_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_MEM      = 3'd4,
    S_WB       = 3'd5,
    S_TRAP     = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R       = 4'd0,
    C_I       = 4'd1,
    C_LOAD    = 4'd2,
    C_STORE   = 4'd3,
    C_BRANCH  = 4'd4,
    C_JAL     = 4'd5,
    C_JALR    = 4'd6,
    C_LUI     = 4'd7,
    C_AUIPC   = 4'd8,
    C_MUL     = 4'd9,
    C_ILLEGAL = 4'd10
  } iclass_t;

  localparam int WAIT_W = (MAX_MEM_WAIT > 1) ? $clog2(MAX_MEM_WAIT) : 1;
  localparam int MUL_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_MEM_WAIT - 1);
  localparam logic [MUL_W-1:0]  MUL_LAST  = MUL_W'(MUL_LAT - 1);

  function automatic iclass_t decode_class(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7);
    iclass_t c;
    c = C_ILLEGAL;
    case (op)
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          c = C_R;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          c = C_R;
        end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
          c = C_MUL;
        end else begin
          c = C_ILLEGAL;
        end
      end
      7'b0010011: begin
        if (f3 == 3'b001 && f7 != 7'b0000000) begin
          c = C_ILLEGAL;
        end else if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) begin
          c = C_ILLEGAL;
        end else begin
          c = C_I;
        end
      end
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b1100011: c = C_BRANCH;
      7'b1101111: c = C_JAL;
      7'b1100111: c = (f3 == 3'b000) ? C_JALR : C_ILLEGAL;
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      default:    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  state_t            state_r, state_nx;
  iclass_t           class_r, dec_class_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_nx;
  logic [MUL_W-1:0]  mul_cnt_r, mul_nx;
  logic              illegal_r, bus_err_r, set_ill_s, set_bus_s;

  logic       mem_req_s, mem_we_s, ir_write_s, pc_write_s, alu_src_s;
  logic       reg_write_s, mul_start_s;
  logic [1:0] pc_src_s, alu_op_s, alu_a_sel_s, wb_sel_s;

  assign dec_class_s = decode_class(bus.opcode, bus.funct3, bus.funct7);

  // State, counters, instruction class and sticky trap flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_FETCH;
      class_r    <= C_R;
      wait_cnt_r <= '0;
      mul_cnt_r  <= '0;
      illegal_r  <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nx;
      wait_cnt_r <= wait_nx;
      mul_cnt_r  <= mul_nx;
      if (state_r == S_DECODE) begin
        class_r <= dec_class_s;
      end
      if (set_ill_s) begin
        illegal_r <= 1'b1;
      end
      if (set_bus_s) begin
        bus_err_r <= 1'b1;
      end
    end
  end

  // Next state and per-state control outputs. Counters fall back to zero
  // in every other state, so they are already clear on entry to FETCH/MEM.
  always_comb begin
    state_nx    = state_r;
    wait_nx     = '0;
    mul_nx      = '0;
    set_ill_s   = 1'b0;
    set_bus_s   = 1'b0;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    pc_src_s    = 2'b00;
    alu_op_s    = 2'b00;
    alu_src_s   = 1'b0;
    alu_a_sel_s = 2'b00;
    reg_write_s = 1'b0;
    wb_sel_s    = 2'b00;
    mul_start_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          ir_write_s = 1'b1;
          state_nx   = S_DECODE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          set_bus_s = 1'b1;
          state_nx  = S_TRAP;
        end else begin
          wait_nx = wait_cnt_r + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_class_s == C_ILLEGAL) begin
          set_ill_s = 1'b1;
          state_nx  = S_TRAP;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_r)
          C_R: begin
            alu_op_s = 2'b10;
            state_nx = S_WB;
          end
          C_I: begin
            alu_op_s  = 2'b11;
            alu_src_s = 1'b1;
            state_nx  = S_WB;
          end
          C_LUI: begin
            alu_src_s   = 1'b1;
            alu_a_sel_s = 2'b10;
            state_nx    = S_WB;
          end
          C_AUIPC: begin
            alu_src_s   = 1'b1;
            alu_a_sel_s = 2'b01;
            state_nx    = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src_s = 1'b1;
            state_nx  = S_MEM;
          end
          C_BRANCH: begin
            alu_op_s   = 2'b01;
            pc_write_s = 1'b1;
            pc_src_s   = bus.branch_taken ? 2'b01 : 2'b00;
            state_nx   = S_FETCH;
          end
          C_JAL, C_JALR: begin
            pc_write_s  = 1'b1;
            pc_src_s    = 2'b10;
            reg_write_s = 1'b1;
            wb_sel_s    = 2'b10;
            alu_src_s   = 1'b1;
            alu_a_sel_s = (class_r == C_JAL) ? 2'b01 : 2'b00;
            state_nx    = S_FETCH;
          end
          C_MUL: begin
            alu_op_s    = 2'b10;
            mul_start_s = 1'b1;
            state_nx    = S_MUL_WAIT;
          end
          default: begin
            state_nx = S_FETCH;
          end
        endcase
      end
      S_MUL_WAIT: begin
        if (mul_cnt_r == MUL_LAST) begin
          state_nx = S_WB;
        end else begin
          mul_nx = mul_cnt_r + MUL_W'(1);
        end
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = (class_r == C_STORE);
        if (bus.mem_ready) begin
          if (class_r == C_STORE) begin
            pc_write_s = 1'b1;
            state_nx   = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          set_bus_s = 1'b1;
          state_nx  = S_TRAP;
        end else begin
          wait_nx = wait_cnt_r + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        wb_sel_s    = (class_r == C_LOAD) ? 2'b01 : 2'b00;
        pc_write_s  = 1'b1;
        state_nx    = S_FETCH;
      end
      S_TRAP: begin
        state_nx = S_TRAP;
      end
      default: begin
        state_nx = S_FETCH;
      end
    endcase
  end

  // While rst is held the FSM sits in FETCH, so every output is forced low.
  assign bus.mem_req       = mem_req_s & ~rst;
  assign bus.mem_we        = mem_we_s & ~rst;
  assign bus.ir_write      = ir_write_s & ~rst;
  assign bus.pc_write      = pc_write_s & ~rst;
  assign bus.pc_src        = rst ? 2'b00 : pc_src_s;
  assign bus.ALUOp         = rst ? 2'b00 : alu_op_s;
  assign bus.ALUSrc        = alu_src_s & ~rst;
  assign bus.alu_a_sel     = rst ? 2'b00 : alu_a_sel_s;
  assign bus.RegWrite      = reg_write_s & ~rst;
  assign bus.wb_sel        = rst ? 2'b00 : wb_sel_s;
  assign bus.mul_start     = mul_start_s & ~rst;
  assign bus.illegal_instr = illegal_r & ~rst;
  assign bus.bus_error     = bus_err_r & ~rst;
  assign bus.state_dbg     = rst ? 3'd0 : state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle traces are
// generated from the instruction-class rules and compared cycle by cycle.
module tb_multicycle_control;

  localparam int MAXW = 15;
  localparam int MLAT = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] aluop;
    logic       alusrc;
    logic [1:0] alu_a;
    logic       regwrite;
    logic [1:0] wb_sel;
    logic       mul_start;
    logic       illegal;
    logic       buserr;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready_a = 1'b0;
  logic       mem_ready_b = 1'b0;

  int   checks = 0;
  int   errors = 0;
  bit   trapped;
  obs_t exp_q[$];
  bit   rdy_q[$];

  always #5 clk = ~clk;

  multicycle_control_if ifa ();
  multicycle_control_if ifb ();

  assign ifa.opcode       = opcode;
  assign ifa.funct3       = funct3;
  assign ifa.funct7       = funct7;
  assign ifa.branch_taken = branch_taken;
  assign ifa.mem_ready    = mem_ready_a;
  assign ifb.opcode       = opcode;
  assign ifb.funct3       = funct3;
  assign ifb.funct7       = funct7;
  assign ifb.branch_taken = branch_taken;
  assign ifb.mem_ready    = mem_ready_b;

  multicycle_control #(.ENABLE_M(1), .MUL_LAT(MLAT), .MAX_MEM_WAIT(MAXW)) dut_m (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  multicycle_control #(.ENABLE_M(0), .MUL_LAT(MLAT), .MAX_MEM_WAIT(MAXW)) dut_nom (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  function automatic obs_t pack_a();
    obs_t o;
    o = {ifa.state_dbg, ifa.mem_req, ifa.mem_we, ifa.ir_write, ifa.pc_write,
         ifa.pc_src, ifa.ALUOp, ifa.ALUSrc, ifa.alu_a_sel, ifa.RegWrite,
         ifa.wb_sel, ifa.mul_start, ifa.illegal_instr, ifa.bus_error};
    return o;
  endfunction

  function automatic obs_t pack_b();
    obs_t o;
    o = {ifb.state_dbg, ifb.mem_req, ifb.mem_we, ifb.ir_write, ifb.pc_write,
         ifb.pc_src, ifb.ALUOp, ifb.ALUSrc, ifb.alu_a_sel, ifb.RegWrite,
         ifb.wb_sel, ifb.mul_start, ifb.illegal_instr, ifb.bus_error};
    return o;
  endfunction

  // Instruction class straight from the ISA legality rules.
  function automatic string classify(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input bit en_m);
    case (op)
      7'b0110011: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) return "r";
        if (f7 == 7'h01 && en_m) return "mul";
        return "bad";
      end
      7'b0010011: begin
        if (f3 == 3'd1 && f7 != 7'h00) return "bad";
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return "bad";
        return "i";
      end
      7'b0000011: return "load";
      7'b0100011: return "store";
      7'b1100011: return "branch";
      7'b1101111: return "jal";
      7'b1100111: return (f3 == 3'd0) ? "jalr" : "bad";
      7'b0110111: return "lui";
      7'b0010111: return "auipc";
      default:    return "bad";
    endcase
  endfunction

  function automatic obs_t rec(input logic [2:0] st);
    obs_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  task automatic push(input obs_t r, input bit rdy);
    exp_q.push_back(r);
    rdy_q.push_back(rdy);
  endtask

  task automatic push_trap(input bit is_bus);
    obs_t r;
    r = rec(3'd6);
    r.buserr  = is_bus;
    r.illegal = !is_bus;
    for (int i = 0; i < 10; i++) push(r, 1'b0);
    trapped = 1'b1;
  endtask

  // Whole-instruction expected trace: fetch wait, decode, execute, then the
  // class-dependent tail (mul wait, memory wait, write-back).
  task automatic build(input logic [31:0] ir, input bit en_m, input int fw,
                       input int mw, input bit tkn);
    obs_t  r;
    string cls;
    bit    is_store;
    exp_q.delete();
    rdy_q.delete();
    trapped = 1'b0;
    r = rec(3'd0);
    r.mem_req = 1'b1;
    for (int i = 0; i < fw && i < MAXW; i++) push(r, 1'b0);
    if (fw >= MAXW) begin
      push_trap(1'b1);
      return;
    end
    r.ir_write = 1'b1;
    push(r, 1'b1);
    push(rec(3'd1), 1'b0);
    cls = classify(ir[6:0], ir[14:12], ir[31:25], en_m);
    if (cls == "bad") begin
      push_trap(1'b0);
      return;
    end
    r = rec(3'd2);
    case (cls)
      "r":      r.aluop = 2'b10;
      "i":      begin r.aluop = 2'b11; r.alusrc = 1'b1; end
      "lui":    begin r.alusrc = 1'b1; r.alu_a = 2'b10; end
      "auipc":  begin r.alusrc = 1'b1; r.alu_a = 2'b01; end
      "load", "store": r.alusrc = 1'b1;
      "branch": begin r.aluop = 2'b01; r.pc_write = 1'b1; r.pc_src = tkn ? 2'b01 : 2'b00; end
      "jal", "jalr": begin
        r.pc_write = 1'b1; r.pc_src = 2'b10; r.regwrite = 1'b1; r.wb_sel = 2'b10;
        r.alusrc = 1'b1; r.alu_a = (cls == "jal") ? 2'b01 : 2'b00;
      end
      "mul":    begin r.aluop = 2'b10; r.mul_start = 1'b1; end
      default:  r = rec(3'd2);
    endcase
    push(r, 1'b0);
    if (cls == "branch" || cls == "jal" || cls == "jalr") return;
    if (cls == "mul") begin
      for (int i = 0; i < MLAT; i++) push(rec(3'd3), 1'b0);
    end
    if (cls == "load" || cls == "store") begin
      is_store = (cls == "store");
      r = rec(3'd4);
      r.mem_req = 1'b1;
      r.mem_we  = is_store;
      for (int i = 0; i < mw && i < MAXW; i++) push(r, 1'b0);
      if (mw >= MAXW) begin
        push_trap(1'b1);
        return;
      end
      r.pc_write = is_store;
      push(r, 1'b1);
      if (is_store) return;
    end
    r = rec(3'd5);
    r.regwrite = 1'b1;
    r.pc_write = 1'b1;
    r.wb_sel   = (cls == "load") ? 2'b01 : 2'b00;
    push(r, 1'b0);
  endtask

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic drive_check(input bit which, input int limit, input string tag);
    obs_t o, e;
    int   n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      e = exp_q.pop_front();
      if (which) mem_ready_b = rdy_q.pop_front();
      else       mem_ready_a = rdy_q.pop_front();
      #1;
      o = which ? pack_b() : pack_a();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s cyc%0d: observed %h expected %h", tag, n, o, e);
      end
      n++;
      @(negedge clk);
    end
    exp_q.delete();
    rdy_q.delete();
    mem_ready_a = 1'b0;
    mem_ready_b = 1'b0;
  endtask

  task automatic do_reset(input bit which);
    obs_t o;
    if (which) begin rst_b = 1'b1; mem_ready_b = 1'b0; end
    else       begin rst_a = 1'b1; mem_ready_a = 1'b0; end
    #1;
    o = which ? pack_b() : pack_a();
    checks++;
    assert (o === '0) else begin
      errors++;
      $error("FAIL reset_zero: observed %h expected %h", o, obs_t'(0));
    end
    @(negedge clk);
    if (which) rst_b = 1'b0;
    else       rst_a = 1'b0;
  endtask

  task automatic run(input bit which, input logic [31:0] ir, input int fw,
                     input int mw, input bit tkn, input int limit, input string tag);
    opcode       = ir[6:0];
    funct3       = ir[14:12];
    funct7       = ir[31:25];
    branch_taken = tkn;
    build(ir, !which, fw, mw, tkn);
    drive_check(which, limit, tag);
    if (trapped) do_reset(which);
  endtask

  initial begin
    logic [6:0]  ops [9];
    logic [6:0]  op, f7;
    logic [31:0] ir;
    int          k, fw, mw;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    @(negedge clk);
    do_reset(1'b0);
    run(1'b0, 32'h003100B3, 0, 0, 1'b0, 1000, "add");
    run(1'b0, 32'h0000A103, 0, 3, 1'b0, 1000, "lw_wait3");
    run(1'b0, 32'h00208463, 0, 0, 1'b1, 1000, "beq_taken");
    run(1'b0, 32'h00208463, 0, 0, 1'b0, 1000, "beq_not");
    run(1'b0, 32'h023100B3, 0, 0, 1'b0, 1000, "mul_op");
    run(1'b0, 32'h008000EF, 0, 0, 1'b0, 1000, "jal");
    run(1'b0, 32'h000080E7, 0, 0, 1'b0, 1000, "jalr");
    run(1'b0, 32'h000090E7, 0, 0, 1'b0, 1000, "jalr_bad_f3");
    run(1'b0, 32'h123450B7, 0, 0, 1'b0, 1000, "lui");
    run(1'b0, 32'h00001097, 0, 0, 1'b0, 1000, "auipc");
    run(1'b0, 32'h40109093, 0, 0, 1'b0, 1000, "slli_bad");
    run(1'b0, 32'h4010D093, 0, 0, 1'b0, 1000, "srai");
    run(1'b0, 32'h0020A023, 0, 0, 1'b0, 1000, "sw");
    run(1'b0, 32'h00500093, MAXW, 0, 1'b0, 1000, "fetch_timeout");
    run(1'b0, 32'h00500093, MAXW - 1, 0, 1'b0, 1000, "fetch_last_ready");
    run(1'b0, 32'h0020A023, 0, MAXW, 1'b0, 1000, "store_timeout");
    run(1'b0, 32'h0000A103, 0, MAXW - 1, 1'b0, 1000, "load_last_ready");
    run(1'b0, 32'h0020A023, 0, 3, 1'b0, 4, "sw_mid_reset");
    do_reset(1'b0);
    run(1'b0, 32'h003100B3, 2, 0, 1'b0, 1000, "add_after_reset");

    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 9);
      op = (k == 9) ? 7'($urandom) : ops[k];
      k  = $urandom_range(0, 3);
      f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : (k == 2) ? 7'h01 : 7'($urandom);
      ir = {f7, 10'($urandom), 3'($urandom), 5'($urandom), op};
      fw = ($urandom_range(0, 24) == 0) ? MAXW : $urandom_range(0, 3);
      mw = ($urandom_range(0, 24) == 0) ? MAXW : $urandom_range(0, 4);
      run(1'b0, ir, fw, mw, 1'($urandom), 1000, "random");
    end

    do_reset(1'b1);
    run(1'b1, 32'h023100B3, 0, 0, 1'b0, 1000, "mul_disabled");
    run(1'b1, 32'h40000033, 1, 0, 1'b0, 1000, "sub_nom");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
